// File: rtl/cabac_byte_feeder_pkg.sv
// Shared types and constants for the CABAC byte feeder.
// Optional feature macro: CABAC_EPB_STRIP_EN (emulation-prevention byte strip).
package cabac_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_INIT,
    FEED_RUN
  } feed_state_t;

  localparam int INIT_BYTES = 3;
  localparam logic [7:0] EPB_BYTE = 8'h03;

endpackage

// File: rtl/cabac_byte_feeder_if.sv
// Upstream byte stream, valid/ready handshake.
// Master drives valid/data, slave returns ready.
interface cabac_byte_feeder_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cabac_byte_feeder_fifo.sv
// Show-ahead synchronous byte FIFO with registered ready.
// Head is read combinationally from storage.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       ready,
  output logic       empty,
  output logic [7:0] head
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (count != FULL_CNT);
  assign head    = mem[rd_ptr];

  // Next occupancy from this cycle's push/pop.
  always_comb begin
    count_d = count;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      ready <= (count_d != FULL_CNT);
    end
  end

  // Byte storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/cabac_byte_feeder.sv
// CABAC bitstream byte source: FIFO, 3-byte init, per-request delivery.
// Optional feature macro: CABAC_EPB_STRIP_EN.
module cabac_byte_feeder
  import cabac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cabac_byte_feeder_if.slave  s,
  input  logic                init_start,
  output logic                init_done,
  output logic [23:0]         init_value,
  input  logic                request_byte,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  output logic                stall,
  output logic                busy,
  output logic [CNT_W-1:0]    bytes_used
);
  feed_state_t state_q;
  feed_state_t state_d;
  logic [1:0]  init_cnt;
  logic        accept;
  logic        drop;
  logic        wr;
  logic        pop;
  logic        empty;
  logic        in_init;
  logic        in_run;
  logic        last_init;

  assign accept    = s.valid & s.ready;
  assign wr        = accept & ~drop;
  assign in_init   = (state_q == FEED_INIT);
  assign in_run    = (state_q == FEED_RUN);
  assign last_init = (init_cnt == 2'(INIT_BYTES - 1));
  assign pop       = ~empty & ~init_start
                   & (in_init | (in_run & request_byte));

  assign byte_valid = ~empty & in_run;
  assign stall      = request_byte & in_run & empty;
  assign busy       = (state_q != FEED_IDLE);

`ifdef CABAC_EPB_STRIP_EN
  logic [1:0] zero_run;

  assign drop = accept & (zero_run == 2'd2)
              & (s.data == EPB_BYTE);

  // Track consecutive zero bytes on the input stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_run <= '0;
    end else if (init_start) begin
      zero_run <= '0;
    end else if (accept) begin
      if (drop || s.data != 8'h00) zero_run <= '0;
      else if (zero_run != 2'd2)   zero_run <= zero_run + 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr),
    .din   (s.data),
    .pop   (pop),
    .ready (s.ready),
    .empty (empty),
    .head  (byte_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FEED_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FEED_IDLE: if (init_start) state_d = FEED_INIT;
      FEED_INIT: begin
        if (init_start)           state_d = FEED_INIT;
        else if (pop && last_init) state_d = FEED_RUN;
      end
      FEED_RUN:  if (init_start) state_d = FEED_INIT;
      default:   state_d = FEED_IDLE;
    endcase
  end

  // Init byte counter, shift register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt   <= '0;
      init_value <= '0;
      init_done  <= 1'b0;
    end else begin
      init_done <= pop & in_init & last_init;
      if (init_start) begin
        init_cnt <= '0;
      end else if (pop && in_init) begin
        init_cnt   <= init_cnt + 1'b1;
        init_value <= {init_value[15:0], byte_out};
      end
    end
  end

  // Saturating count of bytes handed out since init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       bytes_used <= '0;
    else if (init_start)              bytes_used <= '0;
    else if (pop && bytes_used != '1) bytes_used <= bytes_used + 1'b1;
  end

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Scoreboard bench for cabac_byte_feeder.
// Expected bytes queued on accepted pushes, popped on delivery.
module tb_cabac_byte_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        init_done;
  logic [23:0] init_value;
  logic        request_byte = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        stall;
  logic        busy;
  logic [15:0] bytes_used;

  cabac_byte_feeder_if sif ();

  cabac_byte_feeder #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (sif),
    .init_start   (init_start),
    .init_done    (init_done),
    .init_value   (init_value),
    .request_byte (request_byte),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .stall        (stall),
    .busy         (busy),
    .bytes_used   (bytes_used)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         used_m = 0;
  logic [1:0] zr_m = '0;
  logic [7:0] exp_q [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] b);
`ifdef CABAC_EPB_STRIP_EN
    if (zr_m == 2'd2 && b == 8'h03) begin
      zr_m = '0;
    end else begin
      zr_m = (b != 8'h00) ? 2'd0 : ((zr_m == 2'd2) ? 2'd2 : zr_m + 1'b1);
      exp_q.push_back(b);
    end
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic push_b(input logic [7:0] b);
    int n = 0;
    sif.valid = 1'b1;
    sif.data  = b;
    while (!sif.ready && n < 20) begin
      step();
      n++;
    end
    chk("push_rdy", {31'd0, sif.ready}, 32'd1);
    model_push(b);
    step();
    sif.valid = 1'b0;
  endtask

  task automatic do_init();
    init_start = 1'b1;
    used_m = 0;
    zr_m = '0;
    step();
    init_start = 1'b0;
  endtask

  task automatic check_init(string tag, output int n);
    logic [23:0] e;
    e = '0;
    n = 0;
    while (init_done !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("init_seen", {31'd0, init_done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() > 0) begin
        e = {e[15:0], exp_q.pop_front()};
        used_m++;
      end
    end
    chk(tag, {8'd0, init_value}, {8'd0, e});
    chk("init_used", {16'd0, bytes_used}, used_m);
    step();
    chk("done_pulse", {31'd0, init_done}, 32'd0);
  endtask

  task automatic req_cycle(string tag);
    request_byte = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
    end else begin
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      chk(tag, {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      used_m++;
    end
    step();
    request_byte = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    sif.valid = 1'b0;
    sif.data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, sif.ready}, 32'd1);
    chk("rst_done",  {31'd0, init_done}, 32'd0);
    chk("rst_value", {8'd0, init_value}, 32'd0);
    chk("rst_used",  {16'd0, bytes_used}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    push_b(8'h12);
    push_b(8'h34);
    push_b(8'h56);
    do_init();
    check_init("t1_value", n);
    chk("t1_lat", n, 32'd3);

    push_b(8'hAA);
    push_b(8'hBB);
    for (int i = 0; i < 3; i++) req_cycle("t2_byte");
    chk("t2_used", {16'd0, bytes_used}, used_m);

    request_byte = 1'b1;
    sif.valid = 1'b1;
    sif.data  = 8'hCC;
    #1;
    chk("bypass_stall", {31'd0, stall}, 32'd1);
    model_push(8'hCC);
    step();
    sif.valid = 1'b0;
    #1;
    chk("bypass_stall2", {31'd0, stall}, 32'd0);
    chk("bypass_valid", {31'd0, byte_valid}, 32'd1);
    chk("bypass_byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
    used_m++;
    step();
    request_byte = 1'b0;

    push_b(8'h11);
    push_b(8'h22);
    push_b(8'h33);
    push_b(8'h44);
    chk("t3_full", {31'd0, sif.ready}, 32'd0);
    sif.valid = 1'b1;
    sif.data  = 8'h55;
    request_byte = 1'b1;
    #1;
    chk("t3_stall", {31'd0, stall}, 32'd0);
    chk("t3_head", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
    used_m++;
    step();
    sif.valid = 1'b0;
    request_byte = 1'b0;
    chk("t3_ready", {31'd0, sif.ready}, 32'd1);
    for (int i = 0; i < 4; i++) req_cycle("t3_drain");
    chk("t3_used", {16'd0, bytes_used}, used_m);

    push_b(8'h77);
    push_b(8'h88);
    do_init();
    chk("t5_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    push_b(8'h99);
    check_init("t5_value", n);
    chk("t5_valid", {31'd0, byte_valid}, 32'd0);

    push_b(8'h01);
    push_b(8'h02);
    do_init();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_ready", {31'd0, sif.ready}, 32'd1);
    chk("t6_used", {16'd0, bytes_used}, 32'd0);
    chk("t6_value", {8'd0, init_value}, 32'd0);
    chk("t6_done", {31'd0, init_done}, 32'd0);
    exp_q.delete();
    used_m = 0;
    zr_m = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_empty", {31'd0, byte_valid}, 32'd0);
    push_b(8'hAB);
    request_byte = 1'b1;
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_valid", {31'd0, byte_valid}, 32'd0);
    step();
    request_byte = 1'b0;
    push_b(8'hCD);
    push_b(8'hEF);
    do_init();
    check_init("t6_reinit", n);

`ifdef CABAC_EPB_STRIP_EN
    push_b(8'h00);
    push_b(8'h00);
    push_b(8'h03);
    push_b(8'h01);
    push_b(8'h00);
    push_b(8'h03);
    push_b(8'h00);
    for (int i = 0; i < 7; i++) req_cycle("epb_byte");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
